register_file: RTL and testbench
================================

# register_file

Scoreboarded 32×32 RISC-V integer register file that answers the operand-read handshake issued by `control_unit`: `rs1_read`/`rs2_read` requests in, `rs1_value`/`rs2_value` with `rs1_valid`/`rs2_valid` pulses out. Tracks in-flight destination registers so a read of a register with an outstanding writeback stalls until that writeback lands. Sits between the decode/issue stage and the writeback path of the core.

## Interface
Parameters:
- `XLEN`, 32, register width; only 32 is supported.
- `NREG`, 32, register count; x0 is hardwired to zero.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `rs1_read`  in  1  read request, port 1; sampled at each rising edge.
- `rs1_addr`  in  5  register index for port 1.
- `rs1_value`  out  32  signed read data, port 1; meaningful only while `rs1_valid`=1.
- `rs1_valid`  out  1  single-cycle response pulse, port 1.
- `rs2_read`, `rs2_addr`, `rs2_value`, `rs2_valid`: identical second port.
- `rd_reserve`  in  1  an issued instruction will write `rd_reserve_addr`; sets its pending bit.
- `rd_reserve_addr`  in  5  destination to reserve.
- `rd_write`  in  1  writeback strobe.
- `rd_addr`  in  5  writeback destination.
- `rd_value`  in  32  writeback data.
- `reg_busy`  out  32  pending-bit vector; bit 0 is always 0.

## Operation
- Storage: 31 registers x1–x31; a read of x0 returns 0; writes and reserves targeting x0 are ignored.
- Pending bits: a write clears the bit; a reserve sets it. Write and reserve to the same address on the same edge leave the bit set (reserve wins). Reserving an already-pending register leaves it pending; no counting.
- Per-port FSM, two states: IDLE and WAIT.
  - IDLE, `rsN_read`=1, target not pending before the edge (or x0): next cycle `rsN_valid`=1, `rsN_value` = register contents before the edge; state stays IDLE.
  - IDLE, `rsN_read`=1, target pending: latch the address, go to WAIT, `rsN_valid`=0.
  - WAIT: `rsN_read` is ignored. When the latched pending bit is observed clear, issue the response from the array and return to IDLE.
- Pending state is sampled before the edge; a same-edge reserve does not stall that read.
- Both ports operate independently; they may target the same register on the same cycle.

## Timing
- Reset: all registers 0, `reg_busy`=0, `rs1_valid`=`rs2_valid`=0, `rs1_value`=`rs2_value`=0, both FSMs in IDLE. Reset during WAIT abandons the request; no response is issued.
- Unstalled read latency: 1 cycle, from request edge to `rsN_valid`=1. `rsN_valid` is high for exactly one cycle per accepted request.
- Back-to-back requests in IDLE are accepted every cycle.
- Stalled read with the bypass feature absent: the response arrives 1 cycle after the clearing `rd_write` edge.
- Register write takes effect at the edge; a same-edge IDLE read of that address returns the old value unless the bypass feature is compiled in.
- `rsN_value` holds its last value while `rsN_valid`=0.

## Configuration
- `REGFILE_BYPASS_EN` defined: write-to-read forwarding.
  - An IDLE read on the same edge as `rd_write` to the same nonzero address returns `rd_value`.
  - A WAIT port responds on the clearing write edge itself, carrying `rd_value`. Stalled latency is 0 cycles after the write.
- `REGFILE_BYPASS_EN` undefined: no forwarding; behaviour as in Operation/Timing.

## Test plan
- Reset, then write x5=7, then read rs1=x5 and rs2=x0 on the next cycle -> one cycle later `rs1_valid`=`rs2_valid`=1, `rs1_value`=7, `rs2_value`=0; both valids low the following cycle.
- Reserve x3 (`reg_busy`=0x8), read rs1=x3 -> `rs1_valid` stays 0 for 4 cycles. Then write x3=-9 -> `reg_busy`=0 and `rs1_value`=-9 with `rs1_valid`=1, arriving 1 cycle later without bypass and on the same edge with bypass.
- Same edge: write x4=1 and reserve x4 -> `reg_busy[4]`=1. A subsequent read of x4 stalls.
- Same edge: x6 holds 2, write x6=11, and read rs2=x6 -> response 2 without bypass, 11 with bypass.
- Write x0=99 and reserve x0 -> `reg_busy`=0; a read of x0 returns 0 with a 1-cycle latency.
- Read of pending x8 enters WAIT; assert `rst_n`=0 mid-wait -> outputs are zero immediately; after release, no stray `rs1_valid`, x8 reads 0 unstalled.

Source files
------------

// File: rtl/register_file.sv
// register_file: scoreboarded 32x32 integer register file with two independent operand-read ports.
// Latency: 1 cycle for an unstalled read; a stalled read answers 1 cycle after its clearing write (0 with forwarding).
// Backpressure: a read of a pending register parks that port in WAIT, ignoring new requests, until the writeback lands.
// Build option: define REGFILE_BYPASS_EN to forward rd_value to reads that coincide with the write edge.
module register_file #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rs1_read,
  input  logic [4:0]             rs1_addr,
  output logic signed [XLEN-1:0] rs1_value,
  output logic                   rs1_valid,
  input  logic                   rs2_read,
  input  logic [4:0]             rs2_addr,
  output logic signed [XLEN-1:0] rs2_value,
  output logic                   rs2_valid,
  input  logic                   rd_reserve,
  input  logic [4:0]             rd_reserve_addr,
  input  logic                   rd_write,
  input  logic [4:0]             rd_addr,
  input  logic [XLEN-1:0]        rd_value,
  output logic [NREG-1:0]        reg_busy
);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [XLEN-1:0] regs_q  [NREG];
  logic [XLEN-1:0] regs_d  [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  state_t          state_q [2];
  state_t          state_d [2];
  logic [4:0]      addr_q  [2];
  logic [4:0]      addr_d  [2];
  logic [1:0]      valid_q;
  logic [1:0]      valid_d;
  logic [XLEN-1:0] value_q [2];
  logic [XLEN-1:0] value_d [2];

  logic [1:0]      req;
  logic [4:0]      req_addr [2];
  logic            wr_en;
  logic            rsv_en;

  // x0 is never stored or reserved, so both strobes are qualified here once.
  assign req         = {rs2_read, rs1_read};
  assign req_addr[0] = rs1_addr;
  assign req_addr[1] = rs2_addr;
  assign wr_en       = rd_write && (rd_addr != 5'd0);
  assign rsv_en      = rd_reserve && (rd_reserve_addr != 5'd0);

  // Per-port FSM: answer when the target is not pending (or the write is forwarded), otherwise park in WAIT.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      state_d[p] = state_q[p];
      addr_d[p]  = addr_q[p];
      valid_d[p] = 1'b0;
      value_d[p] = value_q[p];
      case (state_q[p])
        S_IDLE: begin
          if (req[p]) begin
            if (req_addr[p] == 5'd0) begin
              valid_d[p] = 1'b1;
              value_d[p] = '0;
            end else if (BYPASS && wr_en && (rd_addr == req_addr[p])) begin
              valid_d[p] = 1'b1;
              value_d[p] = rd_value;
            end else if (!busy_q[req_addr[p]]) begin
              valid_d[p] = 1'b1;
              value_d[p] = regs_q[req_addr[p]];
            end else begin
              state_d[p] = S_WAIT;
              addr_d[p]  = req_addr[p];
            end
          end
        end
        S_WAIT: begin
          // Forward only a write that actually clears the bit; a same-edge re-reserve keeps the port waiting.
          if (BYPASS && wr_en && (rd_addr == addr_q[p]) &&
              !(rsv_en && (rd_reserve_addr == addr_q[p]))) begin
            valid_d[p] = 1'b1;
            value_d[p] = rd_value;
            state_d[p] = S_IDLE;
          end else if (!busy_q[addr_q[p]]) begin
            valid_d[p] = 1'b1;
            value_d[p] = regs_q[addr_q[p]];
            state_d[p] = S_IDLE;
          end
        end
        default: state_d[p] = S_IDLE;
      endcase
    end
  end

  // Scoreboard update: write clears, reserve sets, reserve applied last so it wins on a same-edge collision.
  always_comb begin
    busy_d = busy_q;
    if (wr_en) begin
      busy_d[rd_addr] = 1'b0;
    end
    if (rsv_en) begin
      busy_d[rd_reserve_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Register array update on writeback; slot 0 stays zero.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wr_en) begin
      regs_d[rd_addr] = rd_value;
    end
    regs_d[0] = '0;
  end

  // State registers; reset abandons any parked read without responding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= '0;
      valid_q <= '0;
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      for (int p = 0; p < 2; p++) begin
        state_q[p] <= S_IDLE;
        addr_q[p]  <= '0;
        value_q[p] <= '0;
      end
    end else begin
      busy_q  <= busy_d;
      valid_q <= valid_d;
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
      end
      for (int p = 0; p < 2; p++) begin
        state_q[p] <= state_d[p];
        addr_q[p]  <= addr_d[p];
        value_q[p] <= value_d[p];
      end
    end
  end

  assign rs1_valid = valid_q[0];
  assign rs2_valid = valid_q[1];
  assign rs1_value = value_q[0];
  assign rs2_value = value_q[1];
  assign reg_busy  = busy_q;

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed bench for register_file with a reference model checked every cycle.
// Build with REGFILE_BYPASS_EN defined to exercise the forwarding variant.
module tb_register_file;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n;
  logic               rs1_read, rs2_read;
  logic [4:0]         rs1_addr, rs2_addr;
  logic signed [31:0] rs1_value, rs2_value;
  logic               rs1_valid, rs2_valid;
  logic               rd_reserve, rd_write;
  logic [4:0]         rd_reserve_addr, rd_addr;
  logic [31:0]        rd_value;
  logic [31:0]        reg_busy;

  int n_checks = 0;
  int n_errors = 0;

  register_file dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_read(rs1_read), .rs1_addr(rs1_addr), .rs1_value(rs1_value), .rs1_valid(rs1_valid),
    .rs2_read(rs2_read), .rs2_addr(rs2_addr), .rs2_value(rs2_value), .rs2_valid(rs2_valid),
    .rd_reserve(rd_reserve), .rd_reserve_addr(rd_reserve_addr),
    .rd_write(rd_write), .rd_addr(rd_addr), .rd_value(rd_value),
    .reg_busy(reg_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Architectural view: an array of values, a set of pending registers, and per port
  // at most one outstanding read that completes once its register is no longer pending.
  logic [31:0] m_regs [32];
  logic [31:0] m_busy;
  bit          m_wait [2];
  logic [4:0]  m_waddr [2];
  bit          e_vld [2];
  logic [31:0] e_val [2];

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_busy = '0;
    for (int p = 0; p < 2; p++) begin
      m_wait[p] = 1'b0; m_waddr[p] = '0; e_vld[p] = 1'b0; e_val[p] = '0;
    end
  endfunction

  // Does this edge's writeback supply the value of register a directly?
  function automatic bit forwarded(input logic [4:0] a);
    return BYP && rd_write && (rd_addr == a) && (a != 5'd0);
  endfunction

  function automatic void answer(input int p, input logic [31:0] v);
    e_vld[p] = 1'b1; e_val[p] = v; m_wait[p] = 1'b0;
  endfunction

  always @(posedge clk) begin
    logic [4:0] a;
    logic       r;
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int p = 0; p < 2; p++) begin
        e_vld[p] = 1'b0;
        r = (p == 0) ? rs1_read : rs2_read;
        if (m_wait[p]) begin
          a = m_waddr[p];
          if (forwarded(a) && !(rd_reserve && rd_reserve_addr == a)) answer(p, rd_value);
          else if (!m_busy[a]) answer(p, m_regs[a]);
        end else if (r) begin
          a = (p == 0) ? rs1_addr : rs2_addr;
          if (a == 5'd0) answer(p, 32'd0);
          else if (forwarded(a)) answer(p, rd_value);
          else if (!m_busy[a]) answer(p, m_regs[a]);
          else begin m_wait[p] = 1'b1; m_waddr[p] = a; end
        end
      end
      if (rd_write && rd_addr != 5'd0) begin
        m_regs[rd_addr] = rd_value;
        m_busy[rd_addr] = 1'b0;
      end
      if (rd_reserve && rd_reserve_addr != 5'd0) m_busy[rd_reserve_addr] = 1'b1;
    end
    #1;
    chk("cyc_rs1_valid", rs1_valid, e_vld[0]);
    chk("cyc_rs2_valid", rs2_valid, e_vld[1]);
    chk("cyc_rs1_value", rs1_value, e_val[0]);
    chk("cyc_rs2_value", rs2_value, e_val[1]);
    chk("cyc_reg_busy", reg_busy, m_busy);
  end

  // ---------------- stimulus helpers ----------------
  task automatic clear_strobes();
    rs1_read = 1'b0; rs2_read = 1'b0; rd_reserve = 1'b0; rd_write = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
    clear_strobes();
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] v);
    rd_write = 1'b1; rd_addr = a; rd_value = v;
  endtask

  task automatic rsv(input logic [4:0] a);
    rd_reserve = 1'b1; rd_reserve_addr = a;
  endtask

  task automatic rd1(input logic [4:0] a);
    rs1_read = 1'b1; rs1_addr = a;
  endtask

  task automatic rd2(input logic [4:0] a);
    rs2_read = 1'b1; rs2_addr = a;
  endtask

  // Counts cycles after the current sample until rs1_valid, bounded.
  task automatic wait_rs1(input string nm, input int exp_lat, input logic [31:0] exp_val);
    int lat = 0;
    while (!rs1_valid && lat < 8) begin
      step();
      lat++;
    end
    chk({nm, "_latency"}, lat, exp_lat);
    chk({nm, "_value"}, rs1_value, exp_val);
  endtask

  initial begin
    rst_n = 1'b1;
    rs1_addr = '0; rs2_addr = '0; rd_reserve_addr = '0; rd_addr = '0; rd_value = '0;
    clear_strobes();
    #1 rst_n = 1'b0;
    repeat (2) step();
    chk("rst_rs1_valid", rs1_valid, 1'b0);
    chk("rst_rs2_valid", rs2_valid, 1'b0);
    chk("rst_rs1_value", rs1_value, 32'd0);
    chk("rst_rs2_value", rs2_value, 32'd0);
    chk("rst_reg_busy", reg_busy, 32'd0);
    rst_n = 1'b1;
    step();

    // Basic write then dual read including x0
    wr(5'd5, 32'd7); step();
    rd1(5'd5); rd2(5'd0); step();
    chk("t1_rs1_valid", rs1_valid, 1'b1);
    chk("t1_rs1_value", rs1_value, 32'd7);
    chk("t1_rs2_valid", rs2_valid, 1'b1);
    chk("t1_rs2_value", rs2_value, 32'd0);
    step();
    chk("t1_rs1_valid_drop", rs1_valid, 1'b0);
    chk("t1_rs2_valid_drop", rs2_valid, 1'b0);

    // Stall on reserved x3, released by a write of -9
    rsv(5'd3); step();
    chk("t2_busy_set", reg_busy, 32'h0000_0008);
    rd1(5'd3);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t2_stall_valid", rs1_valid, 1'b0);
    end
    wr(5'd3, -32'sd9); step();
    chk("t2_busy_clear", reg_busy, 32'd0);
    wait_rs1("t2_release", BYP ? 0 : 1, 32'hFFFF_FFF7);

    // Same-edge write and reserve: reserve wins, later read stalls
    wr(5'd4, 32'd1); rsv(5'd4); step();
    chk("t3_busy_x4", reg_busy, 32'h0000_0010);
    rd1(5'd4); step();
    chk("t3_stall_valid", rs1_valid, 1'b0);
    wr(5'd4, 32'd5); step();
    wait_rs1("t3_release", BYP ? 0 : 1, 32'd5);

    // Same-edge write and read of x6
    wr(5'd6, 32'd2); step();
    wr(5'd6, 32'd11); rd2(5'd6); step();
    chk("t4_rs2_valid", rs2_valid, 1'b1);
    chk("t4_rs2_value", rs2_value, BYP ? 32'd11 : 32'd2);

    // x0 write and reserve are ignored
    wr(5'd0, 32'd99); rsv(5'd0); step();
    chk("t5_busy_x0", reg_busy, 32'd0);
    rd1(5'd0); step();
    chk("t5_x0_valid", rs1_valid, 1'b1);
    chk("t5_x0_value", rs1_value, 32'd0);

    // Both ports on one register, then back-to-back reads
    wr(5'd9, 32'h1234_5678); step();
    rd1(5'd9); rd2(5'd9); step();
    chk("t6_same_rs1", rs1_value, 32'h1234_5678);
    chk("t6_same_rs2", rs2_value, 32'h1234_5678);
    rd1(5'd5); step();
    chk("t6_b2b_x5", rs1_value, 32'd7);
    rd1(5'd6); step();
    chk("t6_b2b_x6", rs1_value, 32'd11);
    rd1(5'd3); step();
    chk("t6_b2b_x3", rs1_value, 32'hFFFF_FFF7);

    // Both ports stalled on x10; requests during WAIT are ignored
    rsv(5'd10); step();
    rd1(5'd10); rd2(5'd10); step();
    rd1(5'd5); rd2(5'd5); step();
    wr(5'd10, 32'd42); step();
    repeat (3) step();

    // Reset while waiting on x8
    rsv(5'd8); step();
    rd1(5'd8); step();
    step();
    chk("t7_wait_valid", rs1_valid, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t7_rst_rs1_valid", rs1_valid, 1'b0);
    chk("t7_rst_rs1_value", rs1_value, 32'd0);
    chk("t7_rst_rs2_value", rs2_value, 32'd0);
    chk("t7_rst_busy", reg_busy, 32'd0);
    step();
    rst_n = 1'b1;
    repeat (2) step();
    chk("t7_no_stray_valid", rs1_valid, 1'b0);
    rd1(5'd8); rd2(5'd5); step();
    chk("t7_x8_valid", rs1_valid, 1'b1);
    chk("t7_x8_value", rs1_value, 32'd0);
    chk("t7_x5_cleared", rs2_value, 32'd0);
    repeat (2) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
